// File: rtl/load_wb.sv
// Load/write-back stage: one in-flight load, word read over valid/ready, lane extract + extend,
// single-cycle register file write. Define LOAD_WB_MISALIGN_CHK_EN to reject misaligned LH/LHU/LW.
module load_wb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_rd,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [31:0]           mem_araddr,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rerr,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StWb} state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] rd_q, rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q, ext_data;
    logic                  err_q, err_d;
    logic                  accept, bad_funct3, misalign, req_ok, rd_done, rd_fault;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign accept     = req_valid && req_ready;
    assign bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

`ifdef LOAD_WB_MISALIGN_CHK_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_ok   = !bad_funct3 && !misalign;
    assign rd_done  = (state_q == StData) && mem_rvalid && !mem_rerr;
    assign rd_fault = (state_q == StData) && mem_rvalid && mem_rerr;
    assign err_d    = (accept && !req_ok) || rd_fault;

    // Lane extraction; halfword lane uses addr[1] only, so unchecked odd LH reads the aligned half.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && req_ok) state_d = StAddr;
            StAddr: if (mem_arready) state_d = StData;
            StData: begin
                if (rd_done) state_d = StWb;
                else if (rd_fault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept && req_ok) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                rd_q     <= req_rd;
            end
            if (rd_done) begin
                rf_waddr_q <= rd_q;
                rf_wdata_q <= ext_data;
            end
        end
    end

    always_comb begin
        req_ready   = (state_q == StIdle) && rst_n;
        mem_arvalid = (state_q == StAddr);
        mem_rready  = (state_q == StData);
        rf_wen      = (state_q == StWb) && (rd_q != '0);
        busy        = (state_q != StIdle);
    end

    assign mem_araddr = {addr_q[31:2], 2'b00};
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_load_wb.sv
// Directed bench for load_wb; each task drives one scenario and checks observed values inline.
module tb_load_wb;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid, mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rerr;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy, err;

    int tests_run, tests_failed;

    // Observations of the most recent run_load transaction
    int          ob_wen_cnt, ob_wen_cyc, ob_err_cnt, ob_ar_cnt, ob_idle_cyc, ob_busy_cnt;
    logic        ob_ar_stable, ob_ready0;
    logic [31:0] ob_araddr, ob_wdata;
    logic [4:0]  ob_waddr;

    load_wb #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_rd(req_rd),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rerr(mem_rerr),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request at a negedge (cycle 0) and plays the memory side; cycle c is sampled at
    // the negedge in its middle. Ends one cycle after req_ready returns.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic rerr,
                            input int ar_dly, input int r_dly);
        int   ar_wait, r_wait;
        logic done;
        ob_wen_cnt = 0; ob_wen_cyc = -1; ob_err_cnt = 0; ob_ar_cnt = 0; ob_idle_cyc = -1;
        ob_busy_cnt = 0; ob_ar_stable = 1'b1; ob_araddr = '0; ob_wdata = '0; ob_waddr = '0;
        ar_wait = 0; r_wait = 0; done = 1'b0;
        @(negedge clk);
        ob_ready0  = req_ready;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        req_rd     = rd;
        mem_rdata  = rdata;
        mem_rerr   = rerr;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rf_wen) begin ob_wen_cnt++; ob_wen_cyc = c; end
            if (err) ob_err_cnt++;
            if (busy) ob_busy_cnt++;
            if (mem_arvalid) begin
                if (ob_ar_cnt == 0) ob_araddr = mem_araddr;
                else if (mem_araddr !== ob_araddr) ob_ar_stable = 1'b0;
                ob_ar_cnt++;
                mem_arready = (ar_wait == ar_dly);
                ar_wait++;
            end else begin
                mem_arready = 1'b0;
            end
            if (mem_rready) begin
                mem_rvalid = (r_wait == r_dly);
                r_wait++;
            end else begin
                mem_rvalid = 1'b0;
            end
            if (req_ready) begin
                ob_idle_cyc = c;
                ob_waddr    = rf_waddr;
                ob_wdata    = rf_wdata;
                done        = 1'b1;
            end
        end
        @(negedge clk);
        if (err) ob_err_cnt++;
        if (rf_wen) ob_wen_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, mem_arvalid, mem_rready, rf_wen, busy, err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {req_ready, mem_arvalid, mem_rready, rf_wen, busy, err});
        end
        tests_run++;
        if (mem_araddr !== 32'h0) begin
            tests_failed++; $display("FAIL reset_araddr: got %h want 0", mem_araddr);
        end
        tests_run++;
        if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rf: got %0d/%h want 0/0", rf_waddr, rf_wdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_lw_basic;
        run_load(32'h8000_0004, 3'b010, 5'd5, 32'hDEAD_BEEF, 1'b0, 0, 0);
        tests_run++;
        if (ob_ready0 !== 1'b1) begin
            tests_failed++; $display("FAIL lw_ready0: got %b want 1", ob_ready0);
        end
        tests_run++;
        if (ob_wen_cnt !== 1 || ob_wen_cyc !== 3) begin
            tests_failed++;
            $display("FAIL lw_wen: got cnt %0d cyc %0d want 1/3", ob_wen_cnt, ob_wen_cyc);
        end
        tests_run++;
        if (ob_waddr !== 5'd5 || ob_wdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lw_wb: got %0d/%h want 5/deadbeef", ob_waddr, ob_wdata);
        end
        tests_run++;
        if (ob_araddr !== 32'h8000_0004 || ob_idle_cyc !== 4 || ob_err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL lw_addr_idle: got %h idle %0d err %0d want 80000004/4/0",
                     ob_araddr, ob_idle_cyc, ob_err_cnt);
        end
    endtask

    task automatic test_extract;
        logic [31:0] addrs [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                   32'h8000_0000, 32'h8000_0001, 32'h8000_0002};
        logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b100, 3'b001};
        logic [31:0] rdat  [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h1234_5678,
                                   32'h0000_F00D, 32'h0000_AB00, 32'h7FFF_0000};
        logic [31:0] exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234,
                                   32'hFFFF_F00D, 32'h0000_00AB, 32'h0000_7FFF};
        for (int i = 0; i < 6; i++) begin
            run_load(addrs[i], f3s[i], 5'd7, rdat[i], 1'b0, 0, 0);
            tests_run++;
            if (ob_wdata !== exp[i] || ob_wen_cnt !== 1 || ob_araddr !== {addrs[i][31:2], 2'b00})
            begin
                tests_failed++;
                $display("FAIL extract_%0d: got %h wen %0d araddr %h want %h 1 %h", i, ob_wdata,
                         ob_wen_cnt, ob_araddr, exp[i], {addrs[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_rd_zero;
        run_load(32'h8000_0008, 3'b010, 5'd0, 32'h1111_1111, 1'b0, 0, 0);
        tests_run++;
        if (ob_wen_cnt !== 0 || ob_busy_cnt !== 3 || ob_idle_cyc !== 4) begin
            tests_failed++;
            $display("FAIL rd_zero: got wen %0d busy %0d idle %0d want 0/3/4",
                     ob_wen_cnt, ob_busy_cnt, ob_idle_cyc);
        end
    endtask

    task automatic test_mem_wait;
        run_load(32'h8000_0104, 3'b010, 5'd12, 32'h0BAD_CAFE, 1'b0, 3, 2);
        tests_run++;
        if (ob_wen_cyc !== 8 || ob_wen_cnt !== 1 || ob_idle_cyc !== 9) begin
            tests_failed++;
            $display("FAIL wait_timing: got wen cyc %0d cnt %0d idle %0d want 8/1/9",
                     ob_wen_cyc, ob_wen_cnt, ob_idle_cyc);
        end
        tests_run++;
        if (!ob_ar_stable || ob_ar_cnt !== 4 || ob_araddr !== 32'h8000_0104) begin
            tests_failed++;
            $display("FAIL wait_araddr: got stable %b cnt %0d addr %h want 1/4/80000104",
                     ob_ar_stable, ob_ar_cnt, ob_araddr);
        end
        tests_run++;
        if (ob_wdata !== 32'h0BAD_CAFE || ob_waddr !== 5'd12) begin
            tests_failed++;
            $display("FAIL wait_wb: got %0d/%h want 12/0badcafe", ob_waddr, ob_wdata);
        end
        run_load(32'h8000_0108, 3'b010, 5'd13, 32'h5555_5555, 1'b1, 3, 2);
        tests_run++;
        if (ob_err_cnt !== 1 || ob_wen_cnt !== 0 || ob_idle_cyc !== 8) begin
            tests_failed++;
            $display("FAIL rerr: got err %0d wen %0d idle %0d want 1/0/8",
                     ob_err_cnt, ob_wen_cnt, ob_idle_cyc);
        end
    endtask

    task automatic test_misalign;
        run_load(32'h8000_0001, 3'b001, 5'd9, 32'hABCD_8765, 1'b0, 0, 0);
`ifdef LOAD_WB_MISALIGN_CHK_EN
        tests_run++;
        if (ob_err_cnt !== 1 || ob_ar_cnt !== 0 || ob_wen_cnt !== 0 || ob_idle_cyc !== 1) begin
            tests_failed++;
            $display("FAIL misalign_lh: got err %0d ar %0d wen %0d idle %0d want 1/0/0/1",
                     ob_err_cnt, ob_ar_cnt, ob_wen_cnt, ob_idle_cyc);
        end
        run_load(32'h8000_0002, 3'b010, 5'd9, 32'h1234_5678, 1'b0, 0, 0);
        tests_run++;
        if (ob_err_cnt !== 1 || ob_ar_cnt !== 0) begin
            tests_failed++;
            $display("FAIL misalign_lw: got err %0d ar %0d want 1/0", ob_err_cnt, ob_ar_cnt);
        end
`else
        tests_run++;
        if (ob_wdata !== 32'hFFFF_8765 || ob_err_cnt !== 0 || ob_wen_cnt !== 1) begin
            tests_failed++;
            $display("FAIL misalign_lh: got %h err %0d wen %0d want ffff8765/0/1",
                     ob_wdata, ob_err_cnt, ob_wen_cnt);
        end
        run_load(32'h8000_0002, 3'b010, 5'd9, 32'h1234_5678, 1'b0, 0, 0);
        tests_run++;
        if (ob_wdata !== 32'h1234_5678 || ob_araddr !== 32'h8000_0000 || ob_err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL misalign_lw: got %h addr %h err %0d want 12345678/80000000/0",
                     ob_wdata, ob_araddr, ob_err_cnt);
        end
`endif
    endtask

    task automatic test_bad_funct3;
        logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            run_load(32'h8000_0000, bad[i], 5'd4, 32'h0, 1'b0, 0, 0);
            tests_run++;
            if (ob_err_cnt !== 1 || ob_ar_cnt !== 0 || ob_wen_cnt !== 0 || ob_idle_cyc !== 1) begin
                tests_failed++;
                $display("FAIL bad_funct3_%b: got err %0d ar %0d wen %0d idle %0d want 1/0/0/1",
                         bad[i], ob_err_cnt, ob_ar_cnt, ob_wen_cnt, ob_idle_cyc);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_funct3 = 3'b010; req_rd = 5'd3;
        mem_rerr = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || mem_rready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_in_data: got busy %b rready %b want 1/1", busy, mem_rready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, mem_rready, rf_wen, req_ready, err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_drop: got %b want 00000",
                     {busy, mem_rready, rf_wen, req_ready, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_release: got ready %b err %b want 1/0", req_ready, err);
        end
        run_load(32'h8000_0020, 3'b010, 5'd9, 32'hCAFE_F00D, 1'b0, 0, 0);
        tests_run++;
        if (ob_wen_cyc !== 3 || ob_wdata !== 32'hCAFE_F00D || ob_waddr !== 5'd9) begin
            tests_failed++;
            $display("FAIL mid_after_lw: got cyc %0d %0d/%h want 3 9/cafef00d",
                     ob_wen_cyc, ob_waddr, ob_wdata);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
        test_reset();
        test_lw_basic();
        test_extract();
        test_rd_zero();
        test_mem_wait();
        test_misalign();
        test_bad_funct3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_wb.md
# load_wb

Load/write-back stage of the NPC core that sits directly upstream of the register file write port. It accepts one load request per transaction from execute, performs a word-aligned memory read over a valid/ready handshake, and extracts and extends the byte, halfword or word. It then drives a single-cycle register file write (`rf_wen`/`rf_waddr`/`rf_wdata`). Only one load is in flight at a time; execute stalls on `req_ready`.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register index width; matches register file.
- `DATA_WIDTH`, 32: register/memory data width.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: load request valid from execute.
- `req_ready` out 1: stage can accept a request.
- `req_addr` in 32: byte address of load.
- `req_funct3` in 3: RV32I load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `req_rd` in ADDR_WIDTH: destination register.
- `mem_arvalid` out 1: memory read address valid.
- `mem_arready` in 1: memory accepts address.
- `mem_araddr` out 32: word-aligned read address.
- `mem_rvalid` in 1: read data valid.
- `mem_rready` out 1: stage accepts read data.
- `mem_rdata` in DATA_WIDTH: read data word.
- `mem_rerr` in 1: bus error, qualified by `mem_rvalid`.
- `rf_wen` out 1: register file write enable.
- `rf_waddr` out ADDR_WIDTH: register file write index.
- `rf_wdata` out DATA_WIDTH: register file write data.
- `busy` out 1: state != IDLE.
- `err` out 1: one-cycle pulse on a rejected or faulted load.

## Operation
- Reset (`rst_n` low, asynchronous): state IDLE. `req_ready`, `mem_arvalid`, `mem_rready`, `rf_wen`, `busy` and `err` are 0. `mem_araddr`, `rf_waddr` and `rf_wdata` are 0. Latched request fields are 0.
- `req_ready` = (state == IDLE) and `rst_n` high.
- IDLE:
  - On `req_valid` & `req_ready`: validate the request.
  - Invalid funct3 (011, 110, 111): pulse `err`, stay in IDLE, no memory access.
  - Misaligned request (see Configuration): pulse `err`, stay in IDLE, no memory access.
  - Otherwise: latch addr, funct3 and rd, go to ADDR.
- ADDR: `mem_arvalid`=1, `mem_araddr`={addr[31:2],2'b00}, held stable until `mem_arready`. On `mem_arready`, go to DATA.
- DATA: `mem_rready`=1.
  - On `mem_rvalid` with `mem_rerr`: pulse `err`, go to IDLE, no write.
  - On `mem_rvalid` without `mem_rerr`: register extracted data, go to WB.
- Extraction: byte lane addr[1:0] selects bits [8k+7:8k]; halfword lane addr[1] selects [16h+15:16h]. LB/LH sign-extend to DATA_WIDTH, LBU/LHU zero-extend, LW passes through.
- WB: `rf_waddr`=rd, `rf_wdata`=extracted value. `rf_wen`=1 iff rd != 0, so x0 is never written. Always go to IDLE next cycle.
- `rf_waddr`/`rf_wdata` hold their last values outside WB. `rf_wen` is 0 in every state except WB.
- `err` is registered; it is high exactly one cycle, the cycle after the triggering edge.

## Timing
- Cycle 0: request accepted in IDLE.
- Cycle 1: ADDR. With `mem_arready` high in cycle 1, DATA in cycle 2. With `mem_rvalid` in cycle 2, WB in cycle 3.
- The register file captures the write at the rising edge ending cycle 3.
- IDLE and `req_ready`=1 return in cycle 4. Minimum occupancy is 4 cycles; each memory wait cycle adds 1.
- `mem_arvalid` is never deasserted before `mem_arready`. `mem_rready` is only high in DATA.
- `mem_rvalid` outside DATA is ignored.
- Reset asserted mid-transaction (any state) abandons the load: no `rf_wen`, no `err`. Outputs go to reset values immediately. Memory must tolerate a dropped handshake.
- Request accepted and `err` pulse never coincide with `rf_wen`.

## Configuration
- `LOAD_WB_MISALIGN_CHK_EN` defined:
  - LH/LHU with addr[0]=1 is rejected with an `err` pulse and no memory access.
  - LW with addr[1:0]!=0 is rejected the same way.
- Not defined: no misalignment check.
  - LW ignores addr[1:0].
  - LH/LHU ignore addr[0]; lane is selected by addr[1] only.
  - Such loads proceed normally.

## Test plan
- LW addr 0x8000_0004, rd=5, arready and rvalid immediate, rdata 0xDEADBEEF -> `rf_wen` high in cycle 3 only, waddr 5, wdata 0xDEADBEEF, `mem_araddr` 0x8000_0004.
- LB addr 0x8000_0003, rd=7, rdata 0x80FF_0000 -> wdata 0xFFFF_FF80. Same request as LBU -> wdata 0x0000_0080. LHU addr 0x8000_0002, rdata 0x1234_5678 -> 0x0000_1234.
- LW rd=0, rdata 0x1111_1111 -> full 4-cycle sequence, `rf_wen` stays 0 throughout.
- arready delayed 3 cycles, rvalid delayed 2 -> `mem_araddr` stable, WB in cycle 8. With `mem_rerr`=1 instead -> `err` one-cycle pulse, no write, IDLE.
- LH addr 0x8000_0001:
  - Macro defined: `err` pulse, `mem_arvalid` never asserted.
  - Macro undefined: rdata 0xABCD_8765 -> wdata 0xFFFF_8765.
  - funct3=011 -> `err` in both builds.
- `rst_n` pulled low while in DATA -> `busy`, `mem_rready` and `rf_wen` drop immediately. After release, `req_ready`=1 and a subsequent LW completes normally.
